// File: rtl/alu_muldiv.sv
// alu_muldiv: combinational EX-stage ALU plus an iterative
// radix-2 multiply/divide unit with HI/LO result registers.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ALUSrc,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] RD2,
  input  logic [WIDTH-1:0] SignImm,
  input  logic [SHW-1:0]   sa,
  input  logic [3:0]       ALUControl,
  input  logic             start,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_ADDU  = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_SUBU  = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_SLL   = 4'b0110;
  localparam logic [3:0] OP_SRL   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_BEQ   = 4'b1001;
  localparam logic [3:0] OP_BNE   = 4'b1010;
  localparam logic [3:0] OP_MULT  = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_sum;
  logic             w_sub;
  logic             w_slt;

  // Operand select and the shared adder/subtractor
  always_comb begin
    w_b   = ALUSrc ? SignImm : RD2;
    w_sub = (ALUControl == OP_SUB) || (ALUControl == OP_SUBU) ||
            (ALUControl == OP_BEQ) || (ALUControl == OP_BNE);
    w_bx  = w_sub ? ~w_b : w_b;
    w_sum = SrcA + w_bx + {{(WIDTH-1){1'b0}}, w_sub};
    w_slt = $signed(SrcA) < $signed(RD2);
  end

  // Result mux, zero flag and signed overflow
  always_comb begin
    ALUResult = '0;
    overflow  = 1'b0;
    Zero      = (w_sum == '0);
    case (ALUControl)
      OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
      OP_BEQ, OP_BNE: ALUResult = w_sum;
      OP_AND:         ALUResult = SrcA & RD2;
      OP_OR:          ALUResult = SrcA | RD2;
      OP_SLL:         ALUResult = RD2 << sa;
      OP_SRL:         ALUResult = RD2 >> sa;
      OP_SLT:         ALUResult = {{(WIDTH-1){1'b0}}, w_slt};
      default:        ALUResult = '0;
    endcase
    if (ALUControl == OP_ADD)
      overflow = (SrcA[WIDTH-1] == w_b[WIDTH-1]) &&
                 (w_sum[WIDTH-1] != SrcA[WIDTH-1]);
    else if (ALUControl == OP_SUB)
      overflow = (SrcA[WIDTH-1] != w_b[WIDTH-1]) &&
                 (w_sum[WIDTH-1] != SrcA[WIDTH-1]);
  end

  state_t           r_state;
  logic [SHW-1:0]   r_cnt;
  logic             r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic [WIDTH-1:0] r_a_orig;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic             w_md;
  logic             w_is_div;
  logic             w_signed;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  // Launch decode: op class and operand magnitudes
  always_comb begin
    w_md     = (ALUControl >= OP_MULT) && (ALUControl <= OP_DIVU);
    w_is_div = (ALUControl == OP_DIV) || (ALUControl == OP_DIVU);
    w_signed = (ALUControl == OP_MULT) || (ALUControl == OP_DIV);
    w_a_mag  = (w_signed && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    w_b_mag  = (w_signed && w_b[WIDTH-1]) ? -w_b : w_b;
  end

  logic [WIDTH:0]     w_madd;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_acc_n;
  logic [WIDTH-1:0]   w_q_n;
  logic [2*WIDTH-1:0] w_mres;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  // One shift-add or restoring shift-subtract step, plus sign fix-up
  always_comb begin
    w_madd  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    w_trial = {r_acc, r_q[WIDTH-1]} - {1'b0, r_b};
    if (r_div) begin
      if (!w_trial[WIDTH]) begin
        w_acc_n = w_trial[WIDTH-1:0];
        w_q_n   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_n = {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
        w_q_n   = {r_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_acc_n = w_madd[WIDTH:1];
      w_q_n   = {w_madd[0], r_q[WIDTH-1:1]};
    end
    w_mres = r_neg_q ? -{w_acc_n, w_q_n} : {w_acc_n, w_q_n};
    w_quo  = r_div0 ? '1 : (r_neg_q ? -w_q_n : w_q_n);
    w_rem  = r_div0 ? r_a_orig : (r_neg_r ? -w_acc_n : w_acc_n);
  end

  // Multiply/divide sequencer with registered busy/done and HI/LO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_a_orig <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start && w_md) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_div    <= w_is_div;
            r_neg_q  <= w_signed && (SrcA[WIDTH-1] ^ w_b[WIDTH-1]);
            r_neg_r  <= w_signed && SrcA[WIDTH-1];
            r_div0   <= w_is_div && (w_b == '0);
            r_a_orig <= SrcA;
            r_b      <= w_b_mag;
            r_acc    <= '0;
            r_q      <= w_a_mag;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_n;
          r_q   <= w_q_n;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            if (r_div) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              {r_hi, r_lo} <= w_mres;
            end
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed checks of the ALU and the MD unit
// at WIDTH=32 and WIDTH=16.
module tb_alu_muldiv;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ALUSrc;
  logic        start_a;
  logic        start_b;
  logic [31:0] SrcA;
  logic [31:0] RD2;
  logic [31:0] SignImm;
  logic [4:0]  sa;
  logic [3:0]  ALUControl;

  logic [31:0] res_a, hi_a, lo_a;
  logic        zero_a, ovf_a, busy_a, done_a;
  logic [15:0] res_b, hi_b, lo_b;
  logic        zero_b, ovf_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32)) u_a (
    .clk(clk), .rst_n(rst_n), .ALUSrc(ALUSrc),
    .SrcA(SrcA), .RD2(RD2), .SignImm(SignImm),
    .sa(sa), .ALUControl(ALUControl), .start(start_a),
    .ALUResult(res_a), .Zero(zero_a), .overflow(ovf_a),
    .busy(busy_a), .done(done_a), .hi(hi_a), .lo(lo_a)
  );

  alu_muldiv #(.WIDTH(16)) u_b (
    .clk(clk), .rst_n(rst_n), .ALUSrc(ALUSrc),
    .SrcA(SrcA[15:0]), .RD2(RD2[15:0]),
    .SignImm(SignImm[15:0]),
    .sa(sa[3:0]), .ALUControl(ALUControl), .start(start_b),
    .ALUResult(res_b), .Zero(zero_b), .overflow(ovf_b),
    .busy(busy_b), .done(done_b), .hi(hi_b), .lo(lo_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit w16, input logic v);
    if (w16) start_b = v;
    else start_a = v;
  endtask

  task automatic comb(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] imm,
                      input logic src, input logic [4:0] s);
    ALUControl = op; SrcA = a; RD2 = b;
    SignImm = imm; ALUSrc = src; sa = s;
    #1;
  endtask

  task automatic run_md(input bit w16, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input string tag, input bit inj);
    int lat, nb, w;
    logic dn;
    w = w16 ? 16 : 32;
    ALUControl = op; SrcA = a; RD2 = b; ALUSrc = 1'b0;
    set_start(w16, 1'b1);
    cyc();
    set_start(w16, 1'b0);
    lat = 0; nb = 0;
    dn = w16 ? done_b : done_a;
    while (!dn && lat < 2 * w + 8) begin
      if (w16 ? busy_b : busy_a) nb++;
      if (inj && lat == 5) begin
        set_start(w16, 1'b1);
        SrcA = 32'h3; RD2 = 32'h3;
      end else begin
        set_start(w16, 1'b0);
      end
      cyc();
      lat++;
      dn = w16 ? done_b : done_a;
    end
    set_start(w16, 1'b0);
    chk({tag, "/latency"}, 64'(lat), 64'(w));
    chk({tag, "/busycyc"}, 64'(nb), 64'(w));
    chk({tag, "/hi"}, w16 ? {48'b0, hi_b} : {32'b0, hi_a}, {32'b0, eh});
    chk({tag, "/lo"}, w16 ? {48'b0, lo_b} : {32'b0, lo_a}, {32'b0, el});
    cyc();
    chk({tag, "/donepulse"}, {63'b0, w16 ? done_b : done_a}, 64'd0);
  endtask

  task automatic abort_test(input bit w16, input string tag);
    int w;
    logic seen;
    w = w16 ? 16 : 32;
    ALUControl = 4'b1011; ALUSrc = 1'b0;
    SrcA = w16 ? 32'h0000FFFD : 32'hFFFFFFFD; RD2 = 32'd5;
    set_start(w16, 1'b1);
    cyc();
    set_start(w16, 1'b0);
    repeat (8) cyc();
    chk({tag, "/busy_pre"}, {63'b0, w16 ? busy_b : busy_a}, 64'd1);
    cyc();
    rst_n = 1'b0;
    cyc();
    chk({tag, "/busy_rst"}, {63'b0, w16 ? busy_b : busy_a}, 64'd0);
    chk({tag, "/hi_rst"}, w16 ? {48'b0, hi_b} : {32'b0, hi_a}, 64'd0);
    chk({tag, "/lo_rst"}, w16 ? {48'b0, lo_b} : {32'b0, lo_a}, 64'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (2 * w + 4) begin
      if (w16 ? done_b : done_a) seen = 1'b1;
      cyc();
    end
    chk({tag, "/nodone"}, {63'b0, seen}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    ALUSrc = 1'b0; SrcA = '0; RD2 = '0; SignImm = '0;
    sa = '0; ALUControl = '0;
    cyc(); cyc();
    chk("rst/busy", {63'b0, busy_a}, 64'd0);
    chk("rst/done", {63'b0, done_a}, 64'd0);
    chk("rst/hi", {32'b0, hi_a}, 64'd0);
    chk("rst/lo", {32'b0, lo_a}, 64'd0);
    chk("rst16/hilo", {32'b0, hi_b, lo_b}, 64'd0);
    rst_n = 1'b1;
    cyc();

    comb(4'b0000, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 5'd0);
    chk("add/res", {32'b0, res_a}, 64'h80000000);
    chk("add/ovf", {63'b0, ovf_a}, 64'd1);
    chk("add/zero", {63'b0, zero_a}, 64'd0);
    comb(4'b0001, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 5'd0);
    chk("addu/res", {32'b0, res_a}, 64'h80000000);
    chk("addu/ovf", {63'b0, ovf_a}, 64'd0);
    comb(4'b0010, 32'h80000000, 32'h1, 32'h0, 1'b0, 5'd0);
    chk("sub/res", {32'b0, res_a}, 64'h7FFFFFFF);
    chk("sub/ovf", {63'b0, ovf_a}, 64'd1);
    comb(4'b1001, 32'h1234, 32'h1234, 32'h0, 1'b0, 5'd0);
    chk("beq/zero", {63'b0, zero_a}, 64'd1);
    comb(4'b1010, 32'h1234, 32'h1235, 32'h0, 1'b0, 5'd0);
    chk("bne/zero", {63'b0, zero_a}, 64'd0);
    chk("bne/res", {32'b0, res_a}, 64'hFFFFFFFF);
    comb(4'b0110, 32'h0, 32'h1, 32'h0, 1'b0, 5'd31);
    chk("sll/res", {32'b0, res_a}, 64'h80000000);
    comb(4'b0111, 32'h0, 32'h80000000, 32'h0, 1'b0, 5'd4);
    chk("srl/res", {32'b0, res_a}, 64'h08000000);
    comb(4'b1000, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 5'd0);
    chk("slt/neg", {32'b0, res_a}, 64'd1);
    comb(4'b1000, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0, 5'd0);
    chk("slt/pos", {32'b0, res_a}, 64'd0);
    comb(4'b0100, 32'hF0F0, 32'hFF00, 32'h5, 1'b1, 5'd0);
    chk("and/res", {32'b0, res_a}, 64'hF000);
    comb(4'b0101, 32'hF0F0, 32'hFF00, 32'h5, 1'b1, 5'd0);
    chk("or/res", {32'b0, res_a}, 64'hFFF0);
    comb(4'b0000, 32'd10, 32'd99, 32'hFFFFFFFF, 1'b1, 5'd0);
    chk("addi/res", {32'b0, res_a}, 64'd9);
    comb(4'b1011, 32'd10, 32'd99, 32'h0, 1'b0, 5'd0);
    chk("mdcode/res", {32'b0, res_a}, 64'd0);
    comb(4'b1111, 32'd10, 32'd99, 32'h0, 1'b0, 5'd0);
    chk("rsvd/res", {32'b0, res_a}, 64'd0);
    comb(4'b0000, 32'h7FFF, 32'h1, 32'h0, 1'b0, 5'd0);
    chk("add16/res", {48'b0, res_b}, 64'h8000);
    chk("add16/ovf", {63'b0, ovf_b}, 64'd1);

    ALUControl = 4'b0000; start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    chk("nonmd/busy", {63'b0, busy_a}, 64'd0);

    run_md(1'b0, 4'b1011, 32'hFFFFFFFD, 32'd5,
           32'hFFFFFFFF, 32'hFFFFFFF1, "mult", 1'b0);
    run_md(1'b0, 4'b1100, 32'hFFFFFFFF, 32'd2,
           32'h1, 32'hFFFFFFFE, "multu", 1'b0);
    run_md(1'b0, 4'b1110, 32'd100, 32'd7,
           32'd2, 32'd14, "divu", 1'b0);
    run_md(1'b0, 4'b1101, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFF, 32'hFFFFFFFD, "div", 1'b0);
    run_md(1'b0, 4'b1101, 32'h80000000, 32'hFFFFFFFF,
           32'h0, 32'h80000000, "divmin", 1'b0);
    run_md(1'b0, 4'b1110, 32'd9, 32'd0,
           32'd9, 32'hFFFFFFFF, "divu0", 1'b1);
    run_md(1'b0, 4'b1101, 32'hFFFFFFF7, 32'd0,
           32'hFFFFFFF7, 32'hFFFFFFFF, "div0", 1'b0);

    comb(4'b0000, 32'd1, 32'd2, 32'h0, 1'b0, 5'd0);
    repeat (3) cyc();
    chk("hold/hilo", {hi_a, lo_a}, 64'hFFFFFFF7_FFFFFFFF);

    abort_test(1'b0, "abort32");
    run_md(1'b0, 4'b1011, 32'hFFFFFFFD, 32'd5,
           32'hFFFFFFFF, 32'hFFFFFFF1, "remult", 1'b0);

    run_md(1'b1, 4'b1100, 32'h0000FFFF, 32'd2,
           32'h1, 32'hFFFE, "multu16", 1'b0);
    abort_test(1'b1, "abort16");
    run_md(1'b1, 4'b1011, 32'h0000FFFD, 32'd5,
           32'hFFFF, 32'hFFF1, "remult16", 1'b0);
    run_md(1'b1, 4'b1101, 32'h0000FFF9, 32'd2,
           32'hFFFF, 32'hFFFD, "div16", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised successor to the single-cycle datapath ALU; adds a multi-cycle multiply/divide unit with HI/LO result registers.
- ALU operations (ADD, ADDU, SUB, SUBU, AND, OR, SLL, SRL, SLT, BEQ, BNE) remain combinational, with the same ALUControl encoding.
- MULT, MULTU, DIV and DIVU run as iterative radix-2 operations under a start/busy/done handshake.
- Sits in the EX stage; the control unit stalls the pipeline on busy.

Parameters:
- WIDTH, 32, datapath width in bits (≥8, power of 2).
- SHW, $clog2(WIDTH), shift-amount width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- ALUSrc  in  1  1: operand B = SignImm; 0: operand B = RD2
- SrcA  in  WIDTH  operand A
- RD2  in  WIDTH  register operand B
- SignImm  in  WIDTH  sign-extended immediate
- sa  in  SHW  shift amount
- ALUControl  in  4  operation select
- start  in  1  launch the MD op selected by ALUControl (1011–1110)
- ALUResult  out  WIDTH  combinational ALU result
- Zero  out  1  adder/subtractor output == 0
- overflow  out  1  signed overflow; ADD/SUB only
- busy  out  1  MD iteration in progress
- done  out  1  one-cycle pulse when HI/LO are updated
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- ALUControl encoding:
  - 0000 ADD, 0001 ADDU, 0010 SUB, 0011 SUBU: ALUResult = add/sub result.
  - 0100 AND, 0101 OR: use RD2 as operand B.
  - 0110 SLL, 0111 SRL: RD2 shifted by sa.
  - 1000 SLT: signed compare of SrcA vs RD2.
  - 1001 BEQ, 1010 BNE: subtract.
  - 1011 MULT, 1100 MULTU, 1101 DIV, 1110 DIVU.
  - 1111: reserved.
- ALUResult for MD codes and 1111 = 0.
- Subtract is active for 0010, 0011, 1001, 1010.
- Operand B for add/sub and MD = ALUSrc ? SignImm : RD2.
- Combinational path is independent of busy and valid every cycle.
- overflow:
  - ADD: operands same sign, result sign differs.
  - SUB: operands differ in sign, result sign differs from A.
  - 0 for all other codes.
- Reset (rst_n=0 at a clock edge): hi=0, lo=0, busy=0, done=0, iteration counter=0, FSM=IDLE. Reset aborts any op in progress; no done pulse is produced.
- FSM IDLE:
  - start=1 with an MD code latches both operands, op and sign info.
  - Signed ops convert operands to magnitudes.
  - Next state RUN; busy=1 from the next cycle.
  - start with a non-MD code is ignored.
- FSM RUN:
  - One shift-add (mul) or shift-subtract restoring step (div) per cycle.
  - Exactly WIDTH cycles with busy=1.
  - start is ignored while busy; operand inputs may change freely.
- FSM FINISH: on the edge ending iteration WIDTH:
  - hi/lo are written with sign-corrected results.
  - busy falls; done=1 for exactly that following cycle; FSM returns to IDLE.
  - Total latency: start edge → done high = WIDTH+1 cycles.
  - A new start is accepted in the done cycle.
- Multiply result: {hi,lo} = 2·WIDTH-bit product. MULT is signed two's complement; MULTU is unsigned.
- Divide result: lo = quotient, hi = remainder.
  - DIV truncates toward zero: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - DIV of most-negative by −1: lo = most-negative (wrap), hi = 0.
- Divide by zero (DIV or DIVU): full latency still applies; lo = all ones, hi = dividend (original signed value). No trap.
- hi/lo hold their values between ops; they change only at FINISH or reset.

Test Plan:
- Reset, then ADD SrcA=32'h7FFFFFFF, RD2=1, ALUSrc=0 → ALUResult=32'h80000000, overflow=1, Zero=0. Same operands with ADDU → overflow=0.
- BEQ SrcA=RD2=32'h1234 → Zero=1. SLL RD2=1, sa=31 → 32'h80000000. SLT SrcA=−1, RD2=1 → ALUResult=1.
- MULT SrcA=−3, RD2=5, start pulse → busy high 32 cycles; done at cycle 33; hi=32'hFFFFFFFF, lo=32'hFFFFFFF1. MULTU 32'hFFFFFFFF×2 → hi=1, lo=32'hFFFFFFFE.
- DIVU 100/7 → lo=14, hi=2. DIV −7/2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIV 32'h80000000/−1 → lo=32'h80000000, hi=0.
- DIVU 9/0 → lo=32'hFFFFFFFF, hi=9 after full latency. A second start mid-op with different operands is ignored; the first op's result is returned.
- Start MULT, assert rst_n=0 at cycle 10 → next cycle busy=0, hi=lo=0, no done pulse. Restart the op → correct result after WIDTH+1 cycles. Repeat with WIDTH=16.
